// File: rtl/sw_io_pkg.sv
// Shared types and constants for the switch/LED test interface.
// Bit positions refer to the DE0 slide switch bus SW[9:0].
package sw_io_pkg;

    localparam int SW_W     = 10;
    localparam int DATA_W   = 8;
    localparam int STRB_BIT = 9;
    localparam int MODE_BIT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/sw_debounce.sv
// Single-bit debouncer for an already synchronised switch.
// The output follows the input only after DEBOUNCE_CYCLES consecutive disagreeing edges.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sync,
    output logic o_db
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_db;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= 8'd0;
            r_db  <= 1'b0;
        end else if (i_sync != r_db) begin
            if (r_cnt == CNT_MAX) begin
                r_db  <= i_sync;
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end else begin
            // Any agreement restarts the count, so a bounce must be fully stable to pass.
            r_cnt <= 8'd0;
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/sw_strobe_source.sv
// Switch producer for the picoMIPS input port: synchronises SW[9:0], debounces the
// enter strobe and mode level, and offers one latched byte per press via valid/ack.
module sw_strobe_source
    import sw_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SW_W-1:0]   sw,
    input  logic              ack,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              mode,
    output logic              overrun
);

    logic [SW_W-1:0]   r_s1;
    logic [SW_W-1:0]   r_s2;
    logic              w_strb;
    logic              w_mode;
    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_data;
    logic              r_armed;
    logic              r_overrun;
    logic              w_latch;
    logic              w_arm_set;
    logic              w_ovr_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw;
            r_s2 <= r_s1;
        end
    end

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_strb (
        .i_clk   (clk),
        .i_reset (reset),
        .i_sync  (r_s2[STRB_BIT]),
        .o_db    (w_strb)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .i_clk   (clk),
        .i_reset (reset),
        .i_sync  (r_s2[MODE_BIT]),
        .o_db    (w_mode)
    );

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_arm_set    = 1'b0;
        w_ovr_set    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_strb) begin
                    w_latch      = 1'b1;
                    w_state_next = PEND;
                end
            end
            PEND: begin
                // ack takes priority over a concurrent second press.
                if (ack) begin
                    w_state_next = RELEASE;
                end else if (r_armed && w_strb) begin
                    w_ovr_set = 1'b1;
                end
                if (!w_strb) begin
                    w_arm_set = 1'b1;
                end
            end
            RELEASE: begin
                if (!w_strb) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_armed   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_data  <= r_s2[DATA_W-1:0];
                r_armed <= 1'b0;
            end else if (w_arm_set) begin
                r_armed <= 1'b1;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign data    = r_data;
    assign valid   = (r_state == PEND);
    assign mode    = w_mode;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_sw_strobe_source.sv
// Scoreboard bench for sw_strobe_source: expected bytes and their arrival edge are
// queued by the stimulus and checked by an independent monitor on each valid rise.
module tb_sw_strobe_source;

    typedef struct {
        logic [7:0] byte_v;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [9:0] sw;
    logic       ack;
    logic [7:0] data;
    logic       valid;
    logic       mode;
    logic       overrun;

    int   cyc;
    int   n_vec;
    int   n_err;
    exp_t sb[$];

    sw_strobe_source #(.DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .ack     (ack),
        .data    (data),
        .valid   (valid),
        .mode    (mode),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Set switches and queue the byte expected 7 edges later.
    task automatic press(input logic [9:0] v);
        exp_t e;
        sw = v;
        e.byte_v = v[7:0];
        e.cyc    = cyc + 7;
        sb.push_back(e);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("valid_after_ack", valid, 0);
    endtask

    // Monitor: every valid rise must match the head of the scoreboard.
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && valid && !prev_v) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("mon_data", data, e.byte_v);
                    chk("mon_latency", cyc, e.cyc);
                end
            end
            prev_v = valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        sw    = 10'h3FF;
        ack   = 1'b0;
        step(4);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_mode", mode, 0);
        chk("rst_overrun", overrun, 0);

        // Release with every switch up: byte FF after edge 7.
        begin
            exp_t e;
            reset    = 1'b0;
            e.byte_v = 8'hFF;
            e.cyc    = cyc + 7;
            sb.push_back(e);
        end
        step(6);
        chk("valid_before_e7", valid, 0);
        step(1);
        chk("valid_e7", valid, 1);
        chk("mode_high", mode, 1);
        do_ack();

        sw = 10'h0A5;
        step(10);
        chk("mode_low", mode, 0);
        chk("idle_valid", valid, 0);

        // Basic press, ack at edge 12.
        press(10'h2A5);
        step(11);
        chk("pend_valid", valid, 1);
        chk("pend_data", data, 8'hA5);
        do_ack();
        sw = 10'h000;
        step(10);

        // 3-edge bounce must never produce a strobe.
        sw = 10'h200;
        step(3);
        sw = 10'h000;
        step(15);
        chk("bounce_valid", valid, 0);

        // Mode latency DEBOUNCE_CYCLES+2.
        sw = 10'h100;
        step(5);
        chk("mode_e5", mode, 0);
        step(1);
        chk("mode_e6", mode, 1);
        sw = 10'h000;
        step(8);

        // Second press while pending sets overrun and leaves data alone.
        press(10'h23C);
        step(8);
        sw = 10'h03C;
        step(6);
        sw = 10'h2C3;
        step(10);
        chk("ovr_set", overrun, 1);
        chk("ovr_valid", valid, 1);
        chk("ovr_data", data, 8'h3C);
        do_ack();
        chk("ovr_sticky_ack", overrun, 1);

        // Held switch after ack: no repeat.
        step(12);
        chk("held_no_valid", valid, 0);
        sw = 10'h05A;
        step(8);
        chk("released_no_valid", valid, 0);
        press(10'h25A);
        step(9);
        chk("new_data", data, 8'h5A);
        chk("ovr_sticky_late", overrun, 1);

        // Reset mid-handshake discards the byte.
        reset = 1'b1;
        sw    = 10'h000;
        step(1);
        chk("midrst_valid", valid, 0);
        chk("midrst_data", data, 0);
        chk("midrst_overrun", overrun, 0);
        step(2);
        reset = 1'b0;
        step(10);
        chk("restart_idle", valid, 0);
        press(10'h2E7);
        step(9);
        chk("restart_data", data, 8'hE7);
        do_ack();
        sw = 10'h000;
        step(10);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
